// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: buffers ALU requests, issues them one at a time, waits the result latency and holds a response.
// Optional split OPA/OPB delivery is built when ALU_SEQ_SPLIT_EN is defined.
module alu_issue_sequencer #(
   parameter int DW    = 8,
   parameter int CW    = 4,
   parameter int DEPTH = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [DW-1:0] req_opa,
   input  logic [DW-1:0] req_opb,
   input  logic [CW-1:0] req_cmd,
   input  logic          req_mode,
   input  logic          req_cin,
   input  logic          req_split,
   output logic [1:0]    alu_inp_valid,
   output logic [DW-1:0] alu_opa,
   output logic [DW-1:0] alu_opb,
   output logic [CW-1:0] alu_cmd,
   output logic          alu_mode,
   output logic          alu_cin,
   output logic          alu_ce,
   input  logic [DW:0]   alu_res,
   input  logic          alu_cout,
   input  logic          alu_oflow,
   input  logic          alu_g,
   input  logic          alu_e,
   input  logic          alu_l,
   input  logic          alu_err,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW:0]   rsp_res,
   output logic [5:0]    rsp_flags,
   output logic [CW-1:0] rsp_cmd,
   output logic          rsp_mode
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ISSUE   = 3'd1;
   localparam logic [2:0] WAIT    = 3'd4;
   localparam logic [2:0] RESP    = 3'd5;
`ifdef ALU_SEQ_SPLIT_EN
   localparam logic [2:0] ISSUE_A = 3'd2;
   localparam logic [2:0] ISSUE_B = 3'd3;
   localparam int EW = 2*DW+CW+3;
`else
   localparam int EW = 2*DW+CW+2;
`endif

   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] wdata, head;
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic [2:0]    state;
   logic          push, pop, empty, multi, lat;

`ifdef ALU_SEQ_SPLIT_EN
   assign wdata = {req_split, req_cin, req_mode, req_cmd, req_opb, req_opa};
   assign alu_inp_valid = state == ISSUE ? 2'b11 : state == ISSUE_A ? 2'b01 : state == ISSUE_B ? 2'b10 : 2'b00;
`else
   logic split_unused;
   assign split_unused = req_split;
   assign wdata = {req_cin, req_mode, req_cmd, req_opb, req_opa};
   assign alu_inp_valid = state == ISSUE ? 2'b11 : 2'b00;
`endif

   assign head      = mem[rptr];
   assign empty     = count == '0;
   assign req_ready = count != (AW+1)'(DEPTH);
   assign push      = req_valid && req_ready;
   assign pop       = state == IDLE && !empty;
   assign rsp_valid = state == RESP;
   // multi-stage ALU ops need one extra cycle before their result is valid
   assign multi     = alu_mode && (alu_cmd == CW'(9) || alu_cmd == CW'(10));

   // request storage; contents are qualified by the pointers so no reset is needed
   always_ff @(posedge CLK) begin
      if (push) mem[wptr] <= wdata;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // issue/wait/response sequencing with the ALU-facing and response registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         lat       <= 1'b0;
         alu_ce    <= 1'b0;
         alu_opa   <= '0;
         alu_opb   <= '0;
         alu_cmd   <= '0;
         alu_mode  <= 1'b0;
         alu_cin   <= 1'b0;
         rsp_res   <= '0;
         rsp_flags <= '0;
         rsp_cmd   <= '0;
         rsp_mode  <= 1'b0;
      end else begin
         alu_ce <= 1'b1;
         case (state)
            IDLE: if (!empty) begin
               alu_opa  <= head[DW-1:0];
               alu_opb  <= head[2*DW-1:DW];
               alu_cmd  <= head[2*DW+CW-1:2*DW];
               alu_mode <= head[2*DW+CW];
               alu_cin  <= head[2*DW+CW+1];
`ifdef ALU_SEQ_SPLIT_EN
               state    <= head[EW-1] ? ISSUE_A : ISSUE;
`else
               state    <= ISSUE;
`endif
            end
            ISSUE: begin
               lat   <= multi;
               state <= WAIT;
            end
`ifdef ALU_SEQ_SPLIT_EN
            ISSUE_A: state <= ISSUE_B;
            ISSUE_B: begin
               lat   <= multi;
               state <= WAIT;
            end
`endif
            WAIT: if (lat) lat <= 1'b0;
            else begin
               rsp_res   <= alu_res;
               rsp_flags <= {alu_cout === 1'b1, alu_oflow === 1'b1, alu_g === 1'b1,
                             alu_e === 1'b1, alu_l === 1'b1, alu_err === 1'b1};
               rsp_cmd   <= alu_cmd;
               rsp_mode  <= alu_mode;
               state     <= RESP;
            end
            RESP: if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb_alu_issue_sequencer: directed checks of issue pattern, result latency, response capture, backpressure and reset.
module tb_alu_issue_sequencer;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       req_valid = 1'b0, req_ready;
   logic [7:0] req_opa = '0, req_opb = '0;
   logic [3:0] req_cmd = '0;
   logic       req_mode = 1'b0, req_cin = 1'b0, req_split = 1'b0;
   logic [1:0] alu_inp_valid;
   logic [7:0] alu_opa, alu_opb;
   logic [3:0] alu_cmd;
   logic       alu_mode, alu_cin, alu_ce;
   logic [8:0] alu_res = 9'h155;
   logic [5:0] fl = 6'h3f;
   logic       rsp_valid, rsp_ready = 1'b0;
   logic [8:0] rsp_res;
   logic [5:0] rsp_flags;
   logic [3:0] rsp_cmd;
   logic       rsp_mode;
   int         n_checks = 0, n_fail = 0;
   int         age = 15, pulses = 0;
   logic [7:0] hist = '0;
   logic [8:0] m_res = '0;
   logic [5:0] m_flags = '0;
   logic       m_multi = 1'b0;

   alu_issue_sequencer dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_opa(req_opa), .req_opb(req_opb),
      .req_cmd(req_cmd), .req_mode(req_mode), .req_cin(req_cin), .req_split(req_split),
      .alu_inp_valid(alu_inp_valid), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
      .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_ce(alu_ce),
      .alu_res(alu_res), .alu_cout(fl[5]), .alu_oflow(fl[4]), .alu_g(fl[3]), .alu_e(fl[2]),
      .alu_l(fl[1]), .alu_err(fl[0]),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
      .rsp_cmd(rsp_cmd), .rsp_mode(rsp_mode));

   always #5 CLK = ~CLK;

   // Minimal ALU behaviour: {res, cout, oflow, g, e, l, err}
   function automatic logic [14:0] alu_model(input logic mode, input logic [3:0] cmd, input logic [7:0] a, b);
      logic [8:0] r;
      logic [5:0] f;
      r = '0;
      f = '0;
      if (mode) begin
         if (cmd == 4'd0) begin r = {1'b0, a} + {1'b0, b}; f[5] = r[8]; end
         if (cmd == 4'd8) f[3:1] = {a > b, a == b, a < b};
         if (cmd == 4'd9) r = ({1'b0, a} + 9'd1) * ({1'b0, b} + 9'd1);
         if (cmd == 4'd10) r = {a, 1'b0} * {1'b0, b};
      end else begin
         case (cmd)
            4'd0: r = {1'b0, a & b};
            4'd1: r = {1'b0, ~(a & b)};
            4'd2: r = {1'b0, a | b};
            4'd3: r = {1'b0, ~(a | b)};
            4'd4: r = {1'b0, a ^ b};
            4'd5: r = {1'b0, ~(a ^ b)};
            default: r = '0;
         endcase
      end
      return {r, f};
   endfunction

   // ALU stand-in: result and flags are valid only in the cycle before the capture edge, garbage otherwise
   always @(negedge CLK) begin
      if (alu_inp_valid != 2'b00) begin
         pulses = pulses + 1;
         hist = {hist[5:0], alu_inp_valid};
      end
      if (alu_inp_valid[1]) begin
         age = 0;
         {m_res, m_flags} = alu_model(alu_mode, alu_cmd, alu_opa, alu_opb);
         m_multi = alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10);
      end else if (age < 15) age = age + 1;
      if (age == (m_multi ? 2 : 1)) begin
         alu_res = m_res;
         fl = m_flags;
      end else begin
         alu_res = 9'h155;
         fl = 6'h3f;
      end
   end

   task automatic run_op(input logic mode, input logic [3:0] cmd, input logic [7:0] a, b, input logic split,
                         output int lat, output int np, output logic [7:0] h);
      int p0;
      p0 = pulses;
      @(negedge CLK);
      req_valid = 1'b1; req_mode = mode; req_cmd = cmd; req_opa = a; req_opb = b; req_split = split; req_cin = 1'b0;
      @(negedge CLK);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
      np = pulses - p0;
      h = hist;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(negedge CLK);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1 RST = 1'b0;
      #2;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      n_checks++; if (alu_inp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_inp_valid got %b want 00", alu_inp_valid); end
      n_checks++; if (alu_ce !== 1'b0) begin n_fail++; $display("FAIL reset_alu_ce got %b want 0", alu_ce); end
      n_checks++; if ({alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin} !== 22'd0) begin n_fail++; $display("FAIL reset_alu_ops got %h want 0", {alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin}); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      n_checks++; if ({rsp_res, rsp_flags, rsp_cmd, rsp_mode} !== 20'd0) begin n_fail++; $display("FAIL reset_rsp_fields got %h want 0", {rsp_res, rsp_flags, rsp_cmd, rsp_mode}); end
      @(negedge CLK);
      n_checks++; if (alu_ce !== 1'b0) begin n_fail++; $display("FAIL reset_held_alu_ce got %b want 0", alu_ce); end
      RST = 1'b1;
      @(negedge CLK);
      n_checks++; if (alu_ce !== 1'b1) begin n_fail++; $display("FAIL release_alu_ce got %b want 1", alu_ce); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL release_rsp_valid got %b want 0", rsp_valid); end
   endtask

   task automatic test_add();
      int lat, np;
      logic [7:0] h;
      run_op(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, lat, np, h);
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL add_latency got %0d want 4", lat); end
      n_checks++; if (np != 1 || h[1:0] !== 2'b11) begin n_fail++; $display("FAIL add_pulses got %0d/%b want 1/11", np, h[1:0]); end
      n_checks++; if (rsp_res !== 9'h100) begin n_fail++; $display("FAIL add_res got %h want 100", rsp_res); end
      n_checks++; if (rsp_flags !== 6'b100000) begin n_fail++; $display("FAIL add_flags got %b want 100000", rsp_flags); end
      n_checks++; if (rsp_cmd !== 4'd0 || rsp_mode !== 1'b1) begin n_fail++; $display("FAIL add_echo got %0d/%b want 0/1", rsp_cmd, rsp_mode); end
      repeat (3) @(negedge CLK);
      n_checks++; if (rsp_valid !== 1'b1 || rsp_res !== 9'h100 || rsp_flags !== 6'b100000) begin n_fail++; $display("FAIL add_hold got %b/%h/%b want 1/100/100000", rsp_valid, rsp_res, rsp_flags); end
      finish_rsp();
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_release got %b want 0", rsp_valid); end
   endtask

   task automatic test_compare();
      int lat, np;
      logic [7:0] h;
      run_op(1'b1, 4'd8, 8'd5, 8'd9, 1'b0, lat, np, h);
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL cmp_latency got %0d want 4", lat); end
      n_checks++; if (rsp_flags !== 6'b000010) begin n_fail++; $display("FAIL cmp_flags got %b want 000010", rsp_flags); end
      n_checks++; if (rsp_cmd !== 4'd8) begin n_fail++; $display("FAIL cmp_echo got %0d want 8", rsp_cmd); end
      finish_rsp();
   endtask

   task automatic test_multi();
      int lat, np;
      logic [7:0] h;
      run_op(1'b1, 4'd9, 8'd3, 8'd4, 1'b0, lat, np, h);
      n_checks++; if (lat != 5) begin n_fail++; $display("FAIL mul_latency got %0d want 5", lat); end
      n_checks++; if (rsp_res !== 9'd20) begin n_fail++; $display("FAIL mul_res got %0d want 20", rsp_res); end
      n_checks++; if (np != 1) begin n_fail++; $display("FAIL mul_pulses got %0d want 1", np); end
      finish_rsp();
   endtask

   task automatic test_split();
      int lat, np;
      logic [7:0] h;
      run_op(1'b0, 4'd0, 8'hF0, 8'h3C, 1'b1, lat, np, h);
      n_checks++; if (rsp_res !== 9'h030) begin n_fail++; $display("FAIL split_res got %h want 030", rsp_res); end
`ifdef ALU_SEQ_SPLIT_EN
      n_checks++; if (lat != 5) begin n_fail++; $display("FAIL split_latency got %0d want 5", lat); end
      n_checks++; if (np != 2 || h[3:0] !== 4'b0110) begin n_fail++; $display("FAIL split_pulses got %0d/%b want 2/0110", np, h[3:0]); end
`else
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL split_latency got %0d want 4", lat); end
      n_checks++; if (np != 1 || h[1:0] !== 2'b11) begin n_fail++; $display("FAIL split_pulses got %0d/%b want 1/11", np, h[1:0]); end
`endif
      finish_rsp();
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp_r [5] = '{9'h030, 9'h0CF, 9'h0FC, 9'h003, 9'h0CC};
      logic [5:0] ready_seen;
      int got, cyc;
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         req_valid = 1'b1; req_mode = 1'b0; req_cmd = 4'(i); req_opa = 8'hF0; req_opb = 8'h3C; req_split = 1'b0;
         ready_seen[i] = req_ready;
      end
      @(negedge CLK);
      req_valid = 1'b0;
      n_checks++; if (ready_seen !== 6'b011111) begin n_fail++; $display("FAIL bp_accept got %b want 011111", ready_seen); end
      n_checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full got %b/%b want 0/1", req_ready, rsp_valid); end
      rsp_ready = 1'b1;
      got = 0;
      cyc = 0;
      while (got < 5 && cyc < 100) begin
         if (rsp_valid) begin
            n_checks++; if (rsp_cmd !== 4'(got) || rsp_res !== exp_r[got]) begin n_fail++; $display("FAIL bp_rsp%0d got %0d/%h want %0d/%h", got, rsp_cmd, rsp_res, got, exp_r[got]); end
            got++;
         end
         @(negedge CLK);
         cyc++;
      end
      n_checks++; if (got != 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", got); end
      repeat (8) @(negedge CLK);
      n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drained got %b/%b want 0/1", rsp_valid, req_ready); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      int lat, np;
      logic [7:0] h;
      logic seen;
      rsp_ready = 1'b0;
      @(negedge CLK);
      req_valid = 1'b1; req_mode = 1'b1; req_cmd = 4'd0; req_opa = 8'hFF; req_opb = 8'h01; req_split = 1'b0;
      @(negedge CLK);
      req_cmd = 4'd2;
      @(negedge CLK);
      req_cmd = 4'd4;
      @(negedge CLK);
      req_valid = 1'b0;
      n_checks++; if (alu_inp_valid !== 2'b00 || rsp_valid !== 1'b0 || alu_opa !== 8'hFF) begin n_fail++; $display("FAIL mid_wait_state got %b/%b/%h want 00/0/ff", alu_inp_valid, rsp_valid, alu_opa); end
      RST = 1'b0;
      #1;
      n_checks++; if ({alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin} !== 22'd0 || alu_ce !== 1'b0) begin n_fail++; $display("FAIL mid_rst_alu got %h/%b want 0/0", {alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin}, alu_ce); end
      n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_inp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_rst_ctrl got %b/%b/%b want 1/0/00", req_ready, rsp_valid, alu_inp_valid); end
      @(negedge CLK);
      RST = 1'b1;
      rsp_ready = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge CLK);
         if (rsp_valid || alu_inp_valid != 2'b00) seen = 1'b1;
      end
      rsp_ready = 1'b0;
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_discard got %b want 0", seen); end
      run_op(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, lat, np, h);
      n_checks++; if (lat != 4 || rsp_res !== 9'h100) begin n_fail++; $display("FAIL mid_rst_next got %0d/%h want 4/100", lat, rsp_res); end
      finish_rsp();
   endtask

   initial begin
      test_reset();
      test_add();
      test_compare();
      test_multi();
      test_split();
      test_back_to_back();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
